pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised successor to the sequential-core PC update stage: owns the architectural PC register rather than only computing the next value.
- Selects the next PC per Y86-64 icode and tracks machine status in a RUN/HALTED/FAULT state machine.
- Checks every `ret` target against a circular return-address stack (RAS) and flags mispredictions.
- Sits after memory stage; its `pc` output feeds fetch.

Parameters:
- AW, 64, address/data width of PC, valC, valM, valP.
- RESET_PC, 0, PC value loaded on reset.
- MEM_LIMIT, 2**13, first illegal address; any committed next-PC >= MEM_LIMIT faults.
- RAS_DEPTH, 8, return-stack entries; power of two, >= 2.
- RAS_PW, 3, log2(RAS_DEPTH).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  commit strobe; current instruction retires on this edge.
- icode  in  4  instruction code of retiring instruction.
- cnd  in  1  branch condition from execute.
- valC  in  AW  constant/destination from decode.
- valM  in  AW  memory read value (return address for ret).
- valP  in  AW  fall-through address.
- pc  out  AW  architectural PC.
- stat  out  2  00 AOK, 01 HLT, 10 INS (invalid icode), 11 ADR (address fault).
- ras_count  out  RAS_PW+1  valid RAS entries, 0..RAS_DEPTH.
- ras_mismatch  out  1  one-cycle pulse on ret misprediction or underflow.
- ras_overflow  out  1  sticky; set when a call overwrites the oldest entry.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, stat=00, state RUN, ras_count=0, RAS pointer=0, ras_mismatch=0, ras_overflow=0. RAS entry contents don't care.
- Next-PC select (combinational):
  - icode 0–6, A, B -> valP.
  - 7 -> valC if cnd else valP.
  - 8 -> valC.
  - 9 -> valM.
  - C–F invalid.
- Commit = en & state==RUN. All updates occur on the clk edge where commit is sampled. No commit -> all registers hold, ras_mismatch=0.
- On commit, in priority order:
  - Invalid icode -> state FAULT, stat=10, pc holds, RAS untouched.
  - icode 0 -> state HALTED, stat=01, pc holds (points at the halt instruction), RAS untouched.
  - Next PC >= MEM_LIMIT (unsigned compare, full AW) -> state FAULT, stat=11, pc holds, RAS untouched.
  - Otherwise pc <= next PC and RAS action applies.
- HALTED and FAULT are terminal: en ignored, pc/stat/RAS frozen; only rst exits.
- RAS push (icode 8, committed):
  - Write valP at top pointer; pointer increments modulo RAS_DEPTH.
  - ras_count increments, saturating at RAS_DEPTH.
  - If ras_count was already RAS_DEPTH, the oldest entry is overwritten and ras_overflow sets (sticky until rst).
- RAS pop (icode 9, committed):
  - If ras_count>0: pointer decrements modulo RAS_DEPTH and ras_count decrements. Popped entry is compared with valM; inequality -> ras_mismatch=1 for exactly that cycle.
  - If ras_count==0 (underflow): ras_mismatch=1, pointer and count unchanged.
  - PC always takes valM regardless of the prediction; the RAS is a checker only.
- Pointer wrap: after RAS_DEPTH+k pushes, the next RAS_DEPTH pops return the newest RAS_DEPTH values in LIFO order; further pops underflow.
- Latency: pc, stat, ras_count, ras_mismatch are all registered, valid one edge after commit. Outputs never change without commit or rst.
- rst asserted mid-cycle clears immediately, including a pending ras_mismatch pulse; the first commit after deassertion uses RESET_PC state.

Test Plan:
- Reset, then commit icode 1 with valP=0x0A -> pc=0x0A, stat=00; hold en=0 for 3 cycles -> pc stays 0x0A.
- Commit icode 7, valC=0x100, valP=0x20: cnd=1 -> pc=0x100; repeat with cnd=0 -> pc=0x20.
- Call valC=0x200, valP=0x30, then ret valM=0x30 -> pc=0x200 then 0x30, ras_count 1 then 0, ras_mismatch stays 0. Repeat with ret valM=0x44 -> pc=0x44, one-cycle ras_mismatch=1.
- RAS_DEPTH=8: 10 calls with valP=1..10 -> ras_count=8, ras_overflow=1. 8 rets with matching valM=10..3 -> no mismatch. 9th ret -> underflow pulse, ras_count=0.
- Commit icode 0 -> stat=01, pc unchanged; further en pulses with icode 1 -> no change. rst -> pc=RESET_PC, stat=00.
- icode 0xC -> stat=10. After reset, jmp valC=MEM_LIMIT -> stat=11, pc unchanged, ras_count unchanged.

Source files
------------

// File: rtl/pc_sequencer.sv
// Architectural PC owner for a sequential Y86-64 core: next-PC select, RUN/HALTED/FAULT
// status machine and a circular return-address stack that checks every ret target.
module pc_sequencer #(
    parameter int unsigned    AW        = 64,
    parameter logic [AW-1:0]  RESET_PC  = '0,
    parameter logic [AW-1:0]  MEM_LIMIT = AW'(8192),
    parameter int unsigned    RAS_DEPTH = 8,
    parameter int unsigned    RAS_PW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [AW-1:0]     valC,
    input  logic [AW-1:0]     valM,
    input  logic [AW-1:0]     valP,
    output logic [AW-1:0]     pc,
    output logic [1:0]        stat,
    output logic [RAS_PW:0]   ras_count,
    output logic              ras_mismatch,
    output logic              ras_overflow
);

    typedef enum logic [1:0] {StRun, StHalted, StFault} state_e;

    localparam logic [1:0] StatAok = 2'b00;
    localparam logic [1:0] StatHlt = 2'b01;
    localparam logic [1:0] StatIns = 2'b10;
    localparam logic [1:0] StatAdr = 2'b11;

    localparam logic [RAS_PW:0]   RasFull = (RAS_PW+1)'(RAS_DEPTH);
    localparam logic [RAS_PW-1:0] PtrOne  = RAS_PW'(1);

    state_e              state_q;
    logic [RAS_PW-1:0]   ptr_q;
    logic [AW-1:0]       ras_mem [RAS_DEPTH];

    logic [AW-1:0]       next_pc;
    logic                icode_valid;
    logic                commit;
    logic                is_halt;
    logic                addr_fault;
    logic                retire;
    logic                push;
    logic                pop;
    logic [AW-1:0]       ras_top;

    always_comb begin
        next_pc     = valP;
        icode_valid = 1'b1;
        case (icode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: next_pc = valP;
            4'h7:    next_pc = cnd ? valC : valP;
            4'h8:    next_pc = valC;
            4'h9:    next_pc = valM;
            default: icode_valid = 1'b0;
        endcase
    end

    // Priority: invalid icode, then halt, then address fault, then normal retire.
    assign commit     = en && (state_q == StRun);
    assign is_halt    = (icode == 4'h0);
    assign addr_fault = (next_pc >= MEM_LIMIT);
    assign retire     = commit && icode_valid && !is_halt && !addr_fault;
    assign push       = retire && (icode == 4'h8);
    assign pop        = retire && (icode == 4'h9);
    // Pointer addresses the next free slot; the newest entry sits one below it.
    assign ras_top    = ras_mem[ptr_q - PtrOne];

    // Entry contents need no reset; only pointer and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[ptr_q] <= valP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            pc           <= RESET_PC;
            stat         <= StatAok;
            ptr_q        <= '0;
            ras_count    <= '0;
            ras_mismatch <= 1'b0;
            ras_overflow <= 1'b0;
        end else begin
            ras_mismatch <= 1'b0;
            if (commit) begin
                if (!icode_valid) begin
                    state_q <= StFault;
                    stat    <= StatIns;
                end else if (is_halt) begin
                    state_q <= StHalted;
                    stat    <= StatHlt;
                end else if (addr_fault) begin
                    state_q <= StFault;
                    stat    <= StatAdr;
                end else begin
                    pc <= next_pc;
                    if (push) begin
                        ptr_q <= ptr_q + PtrOne;
                        if (ras_count == RasFull) begin
                            ras_overflow <= 1'b1;
                        end else begin
                            ras_count <= ras_count + 1'b1;
                        end
                    end
                    if (pop) begin
                        if (ras_count != '0) begin
                            ptr_q        <= ptr_q - PtrOne;
                            ras_count    <= ras_count - 1'b1;
                            ras_mismatch <= (ras_top != valM);
                        end else begin
                            ras_mismatch <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed vector table plus hand-written
// sequences for RAS wrap/underflow, terminal states and asynchronous reset.
module tb_pc_sequencer;

    localparam int unsigned   AW        = 64;
    localparam logic [AW-1:0] RESET_PC  = '0;
    localparam logic [AW-1:0] MEM_LIMIT = 64'd8192;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [3:0]    icode;
    logic          cnd;
    logic [AW-1:0] valC, valM, valP;
    logic [AW-1:0] pc;
    logic [1:0]    stat;
    logic [3:0]    ras_count;
    logic          ras_mismatch;
    logic          ras_overflow;

    int tests = 0;
    int fails = 0;

    pc_sequencer #(
        .AW        (AW),
        .RESET_PC  (RESET_PC),
        .MEM_LIMIT (MEM_LIMIT),
        .RAS_DEPTH (8),
        .RAS_PW    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .icode        (icode),
        .cnd          (cnd),
        .valC         (valC),
        .valM         (valM),
        .valP         (valP),
        .pc           (pc),
        .stat         (stat),
        .ras_count    (ras_count),
        .ras_mismatch (ras_mismatch),
        .ras_overflow (ras_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          en;
        logic [3:0]    icode;
        logic          cnd;
        logic [AW-1:0] valC;
        logic [AW-1:0] valM;
        logic [AW-1:0] valP;
        logic [AW-1:0] exp_pc;
        logic [1:0]    exp_stat;
        logic [3:0]    exp_cnt;
        logic          exp_mis;
        logic          exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic e, logic [3:0] ic, logic c,
                                logic [AW-1:0] vc, logic [AW-1:0] vm, logic [AW-1:0] vp,
                                logic [AW-1:0] xpc, logic [1:0] xst, logic [3:0] xcnt,
                                logic xmis, logic xovf);
        vec_t v;
        v.name = n; v.en = e; v.icode = ic; v.cnd = c;
        v.valC = vc; v.valM = vm; v.valP = vp;
        v.exp_pc = xpc; v.exp_stat = xst; v.exp_cnt = xcnt;
        v.exp_mis = xmis; v.exp_ovf = xovf;
        return v;
    endfunction

    task automatic chk(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string name, logic [AW-1:0] xpc, logic [1:0] xst,
                           logic [3:0] xcnt, logic xmis, logic xovf);
        chk({name, ".pc"}, pc, xpc);
        chk({name, ".stat"}, AW'(stat), AW'(xst));
        chk({name, ".ras_count"}, AW'(ras_count), AW'(xcnt));
        chk({name, ".ras_mismatch"}, AW'(ras_mismatch), AW'(xmis));
        chk({name, ".ras_overflow"}, AW'(ras_overflow), AW'(xovf));
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic step(logic e, logic [3:0] ic, logic c,
                        logic [AW-1:0] vc, logic [AW-1:0] vm, logic [AW-1:0] vp);
        en = e; icode = ic; cnd = c; valC = vc; valM = vm; valP = vp;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle: outputs must clear without an edge.
    task automatic mid_reset(string name);
        #1;
        en = 1'b0;
        rst = 1'b1;
        #1;
        chk_all(name, RESET_PC, 2'b00, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; icode = 4'h1; cnd = 1'b0;
        valC = '0; valM = '0; valP = '0;
        #12;
        chk_all("reset", RESET_PC, 2'b00, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        tbl.push_back(mk("nop",      1, 4'h1, 0, 64'h0,    64'h0,  64'h0A, 64'h0A,  2'b00, 4'd0, 0, 0));
        tbl.push_back(mk("hold1",    0, 4'h8, 0, 64'h500,  64'h0,  64'h77, 64'h0A,  2'b00, 4'd0, 0, 0));
        tbl.push_back(mk("hold2",    0, 4'h9, 0, 64'h0,    64'h66, 64'h0,  64'h0A,  2'b00, 4'd0, 0, 0));
        tbl.push_back(mk("hold3",    0, 4'h0, 0, 64'h0,    64'h0,  64'h0,  64'h0A,  2'b00, 4'd0, 0, 0));
        tbl.push_back(mk("jxx_t",    1, 4'h7, 1, 64'h100,  64'h0,  64'h20, 64'h100, 2'b00, 4'd0, 0, 0));
        tbl.push_back(mk("jxx_nt",   1, 4'h7, 0, 64'h100,  64'h0,  64'h20, 64'h20,  2'b00, 4'd0, 0, 0));
        tbl.push_back(mk("call1",    1, 4'h8, 0, 64'h200,  64'h0,  64'h30, 64'h200, 2'b00, 4'd1, 0, 0));
        tbl.push_back(mk("ret_ok",   1, 4'h9, 0, 64'h0,    64'h30, 64'h0,  64'h30,  2'b00, 4'd0, 0, 0));
        tbl.push_back(mk("call2",    1, 4'h8, 0, 64'h200,  64'h0,  64'h30, 64'h200, 2'b00, 4'd1, 0, 0));
        tbl.push_back(mk("ret_bad",  1, 4'h9, 0, 64'h0,    64'h44, 64'h0,  64'h44,  2'b00, 4'd0, 1, 0));
        tbl.push_back(mk("pulse_end",0, 4'h1, 0, 64'h0,    64'h0,  64'h0,  64'h44,  2'b00, 4'd0, 0, 0));
        tbl.push_back(mk("icA",      1, 4'hA, 1, 64'h900,  64'h0,  64'h60, 64'h60,  2'b00, 4'd0, 0, 0));
        tbl.push_back(mk("icB",      1, 4'hB, 1, 64'h900,  64'h0,  64'h70, 64'h70,  2'b00, 4'd0, 0, 0));
        tbl.push_back(mk("lim_m1",   1, 4'h8, 0, 64'h1FFF, 64'h0,  64'h78, 64'h1FFF,2'b00, 4'd1, 0, 0));
        tbl.push_back(mk("ret_lim",  1, 4'h9, 0, 64'h0,    64'h78, 64'h0,  64'h78,  2'b00, 4'd0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].icode, tbl[i].cnd, tbl[i].valC, tbl[i].valM, tbl[i].valP);
            chk_all(tbl[i].name, tbl[i].exp_pc, tbl[i].exp_stat, tbl[i].exp_cnt,
                    tbl[i].exp_mis, tbl[i].exp_ovf);
        end

        // Ten calls into an eight-entry stack: count saturates, overflow sticks.
        for (int i = 1; i <= 10; i++) begin
            step(1, 4'h8, 0, 64'h400 + AW'(i), 64'h0, AW'(i));
            chk_all($sformatf("call_%0d", i), 64'h400 + AW'(i), 2'b00,
                    (i > 8) ? 4'd8 : 4'(i), 1'b0, (i > 8));
        end
        // Newest eight survive in LIFO order: 10 down to 3.
        for (int j = 0; j < 8; j++) begin
            step(1, 4'h9, 0, 64'h0, AW'(10 - j), 64'h0);
            chk_all($sformatf("ret_%0d", j), AW'(10 - j), 2'b00, 4'(7 - j), 1'b0, 1'b1);
        end
        step(1, 4'h9, 0, 64'h0, 64'h99, 64'h0);
        chk_all("underflow", 64'h99, 2'b00, 4'd0, 1'b1, 1'b1);

        // Halt is terminal.
        step(1, 4'h0, 0, 64'h0, 64'h0, 64'h123);
        chk_all("halt", 64'h99, 2'b01, 4'd0, 1'b0, 1'b1);
        step(1, 4'h1, 0, 64'h0, 64'h0, 64'h5);
        chk_all("halt_hold1", 64'h99, 2'b01, 4'd0, 1'b0, 1'b1);
        step(1, 4'h8, 0, 64'h300, 64'h0, 64'h6);
        chk_all("halt_hold2", 64'h99, 2'b01, 4'd0, 1'b0, 1'b1);
        mid_reset("rst_halt");

        // Invalid icode faults and freezes.
        step(1, 4'hC, 0, 64'h0, 64'h0, 64'h10);
        chk_all("ins", RESET_PC, 2'b10, 4'd0, 1'b0, 1'b0);
        step(1, 4'h1, 0, 64'h0, 64'h0, 64'h10);
        chk_all("ins_hold", RESET_PC, 2'b10, 4'd0, 1'b0, 1'b0);
        mid_reset("rst_ins");

        // Reset must kill a pending mismatch pulse.
        step(1, 4'h9, 0, 64'h0, 64'h10, 64'h0);
        chk_all("empty_ret", 64'h10, 2'b00, 4'd0, 1'b1, 1'b0);
        mid_reset("rst_pulse");

        // Address fault at exactly MEM_LIMIT leaves pc and RAS intact.
        step(1, 4'h8, 0, 64'h80, 64'h0, 64'h18);
        chk_all("call_pre", 64'h80, 2'b00, 4'd1, 1'b0, 1'b0);
        step(1, 4'h7, 1, MEM_LIMIT, 64'h0, 64'h90);
        chk_all("adr", 64'h80, 2'b11, 4'd1, 1'b0, 1'b0);
        step(1, 4'h9, 0, 64'h0, 64'h18, 64'h0);
        chk_all("adr_hold", 64'h80, 2'b11, 4'd1, 1'b0, 1'b0);
        mid_reset("rst_adr");

        // Call to an out-of-range target must not push.
        step(1, 4'h8, 0, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h18);
        chk_all("call_adr", RESET_PC, 2'b11, 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
